// File: rtl/spi_pkg.sv
// spi_pkg: widths and receiver state encoding shared by the SPI frame master and receiver.
package spi_pkg;
    localparam int FRAME_W = 60;
    localparam int HDR_W   = 12;
    localparam int DATA_W  = FRAME_W - HDR_W;
    localparam int CNT_W   = 8;
    typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, TAIL} rx_state_t;
endpackage

// File: rtl/spi_shift_in.sv
// spi_shift_in: MSB-first shift register with bit counter; clear+shift_en together start a new frame.
module spi_shift_in #(
    parameter int W = 60
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_shift_en,
    input  logic         i_sdi,
    input  logic         i_clear,
    output logic [W-1:0] o_word,
    output logic         o_last_bit
);
    localparam int CW = $clog2(W);
    logic [W-1:0]  r_word;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_word <= i_shift_en ? W'(i_sdi) : '0;
            r_cnt  <= i_shift_en ? CW'(1) : '0;
        end else if (i_shift_en) begin
            r_word <= {r_word[W-2:0], i_sdi};
            r_cnt  <= r_cnt + 1'b1;
        end
    end
    assign o_word     = r_word;
    assign o_last_bit = (r_cnt == CW'(W - 1));
endmodule

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: SPI slave that reassembles fixed-length frames into a one-entry valid/ready
// output register, flagging short/long frames and overflow, and counting committed frames.
module spi_frame_receiver #(
    parameter int FRAME_W = spi_pkg::FRAME_W,
    parameter int HDR_W   = spi_pkg::HDR_W,
    parameter int CNT_W   = spi_pkg::CNT_W
) (
    input  logic                     SPI_CLK,
    input  logic                     reset,
    input  logic                     SPI_CSB,
    input  logic                     SPI_SDI,
    input  logic                     frame_ready,
    input  logic                     err_clr,
    output logic                     frame_valid,
    output logic [HDR_W-1:0]         frame_hdr,
    output logic [FRAME_W-HDR_W-1:0] frame_data,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     err_short,
    output logic                     err_long,
    output logic                     overflow
);
    import spi_pkg::*;
    rx_state_t r_state, w_next;
    logic w_shift_en, w_clear, w_commit, w_set_short, w_set_long, w_last_bit, w_room;
    logic [FRAME_W-1:0] w_word, w_frame;
    logic r_valid, r_short, r_long, r_ovf;
    logic [HDR_W-1:0] r_hdr;
    logic [FRAME_W-HDR_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;

    spi_shift_in #(.W(FRAME_W)) u_shift (
        .i_clk      (SPI_CLK),
        .i_rst      (reset),
        .i_shift_en (w_shift_en),
        .i_sdi      (SPI_SDI),
        .i_clear    (w_clear),
        .o_word     (w_word),
        .o_last_bit (w_last_bit)
    );

    // the final bit is merged combinationally so the frame commits on the edge that samples it
    assign w_frame = {w_word[FRAME_W-2:0], SPI_SDI};
    assign w_room  = !r_valid || frame_ready;

    always_comb begin
        w_next      = r_state;
        w_shift_en  = 1'b0;
        w_clear     = 1'b0;
        w_commit    = 1'b0;
        w_set_short = 1'b0;
        w_set_long  = 1'b0;
        unique case (r_state)
            WAIT_HIGH: begin
                w_clear = 1'b1;
                w_next  = SPI_CSB ? IDLE : WAIT_HIGH;
            end
            IDLE: begin
                w_clear    = !SPI_CSB;
                w_shift_en = !SPI_CSB;
                w_next     = SPI_CSB ? IDLE : SHIFT;
            end
            SHIFT: begin
                w_set_short = SPI_CSB;
                w_clear     = SPI_CSB;
                w_commit    = !SPI_CSB && w_last_bit;
                w_shift_en  = !SPI_CSB && !w_last_bit;
                w_next      = SPI_CSB ? IDLE : (w_last_bit ? TAIL : SHIFT);
            end
            TAIL: begin
                w_set_long = !SPI_CSB;
                w_next     = SPI_CSB ? IDLE : WAIT_HIGH;
            end
            default: w_next = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge SPI_CLK) begin
        if (reset) r_state <= WAIT_HIGH;
        else r_state <= w_next;
    end

    always_ff @(posedge SPI_CLK) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_hdr   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_commit && w_room) begin
                r_valid <= 1'b1;
                r_hdr   <= w_frame[FRAME_W-1 -: HDR_W];
                r_data  <= w_frame[FRAME_W-HDR_W-1:0];
                r_count <= r_count + 1'b1;
            end else if (r_valid && frame_ready) begin
                r_valid <= 1'b0;
            end
            r_short <= w_set_short || (r_short && !err_clr);
            r_long  <= w_set_long || (r_long && !err_clr);
            r_ovf   <= (w_commit && !w_room) || (r_ovf && !err_clr);
        end
    end

    assign frame_valid = r_valid;
    assign frame_hdr   = r_hdr;
    assign frame_data  = r_data;
    assign frame_count = r_count;
    assign err_short   = r_short;
    assign err_long    = r_long;
    assign overflow    = r_ovf;
endmodule
